// File: rtl/ws2812_pixel_serializer.sv
// Pixel-to-bit serializer feeding the WS2812B bit generator: takes 24-bit GRB words,
// emits one genMode per generator slot MSB-first, and closes each frame with a RET period.
module ws2812_pixel_serializer #(
    parameter int BITS_PER_PIXEL = 24,
    parameter int RET_SLOTS      = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BITS_PER_PIXEL-1:0] pixelData,
    input  logic                      pixelValid,
    input  logic                      pixelLast,
    output logic                      pixelReady,
    input  logic                      genDone,
    output logic [1:0]                genMode,
    output logic                      doGen,
    output logic                      busy,
    output logic                      frameDone,
    output logic                      underrun
);

    localparam int BIT_CNT_W = $clog2(BITS_PER_PIXEL);
    localparam int RET_CNT_W = $clog2(RET_SLOTS + 1);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LOAD = BIT_CNT_W'(BITS_PER_PIXEL - 1);
    localparam logic [RET_CNT_W-1:0] RET_CNT_LOAD = RET_CNT_W'(RET_SLOTS - 1);

    localparam logic [1:0] MODE_RET = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RET  = 2'd2
    } stateType;

    stateType                  stateReg,     stateNext;
    logic                      holdValidReg, holdValidNext;
    logic [BITS_PER_PIXEL-1:0] holdDataReg,  holdDataNext;
    logic                      holdLastReg,  holdLastNext;
    logic [BITS_PER_PIXEL-1:0] shiftReg,     shiftNext;
    logic                      lastFlagReg,  lastFlagNext;
    logic [BIT_CNT_W-1:0]      bitCntReg,    bitCntNext;
    logic [RET_CNT_W-1:0]      retCntReg,    retCntNext;
    logic [1:0]                genModeReg,   genModeNext;
    logic                      doGenReg,     doGenNext;
    logic                      frameDoneReg, frameDoneNext;
    logic                      underrunReg,  underrunNext;

    logic                      accept;
    logic                      nextAvail;
    logic [BITS_PER_PIXEL-1:0] nextData;
    logic                      nextLast;

    assign accept = pixelValid && !holdValidReg;

    // The pixel that follows the current one: the hold register if occupied,
    // otherwise a word being accepted this very cycle (bypass).
    assign nextAvail = holdValidReg || accept;
    assign nextData  = holdValidReg ? holdDataReg : pixelData;
    assign nextLast  = holdValidReg ? holdLastReg : pixelLast;

    always_comb begin
        stateNext     = stateReg;
        holdValidNext = holdValidReg;
        holdDataNext  = holdDataReg;
        holdLastNext  = holdLastReg;
        shiftNext     = shiftReg;
        lastFlagNext  = lastFlagReg;
        bitCntNext    = bitCntReg;
        retCntNext    = retCntReg;
        genModeNext   = genModeReg;
        doGenNext     = doGenReg;
        frameDoneNext = 1'b0;
        underrunNext  = 1'b0;

        if (accept) begin
            holdValidNext = 1'b1;
            holdDataNext  = pixelData;
            holdLastNext  = pixelLast;
        end

        case (stateReg)
            IDLE: begin
                genModeNext = MODE_RET;
                doGenNext   = 1'b0;
                if (holdValidReg) begin
                    shiftNext     = holdDataReg;
                    lastFlagNext  = holdLastReg;
                    holdValidNext = 1'b0;
                    bitCntNext    = BIT_CNT_LOAD;
                    genModeNext   = {1'b1, holdDataReg[BITS_PER_PIXEL-1]};
                    doGenNext     = 1'b1;
                    stateNext     = SEND;
                end
            end

            SEND: begin
                if (genDone) begin
                    if (bitCntReg != '0) begin
                        shiftNext   = {shiftReg[BITS_PER_PIXEL-2:0], 1'b0};
                        bitCntNext  = bitCntReg - 1'b1;
                        genModeNext = {1'b1, shiftReg[BITS_PER_PIXEL-2]};
                    end else if (lastFlagReg) begin
                        genModeNext = MODE_RET;
                        retCntNext  = RET_CNT_LOAD;
                        stateNext   = RET;
                    end else if (nextAvail) begin
                        // Either source is consumed here, so the hold register ends empty.
                        shiftNext     = nextData;
                        lastFlagNext  = nextLast;
                        holdValidNext = 1'b0;
                        bitCntNext    = BIT_CNT_LOAD;
                        genModeNext   = {1'b1, nextData[BITS_PER_PIXEL-1]};
                    end else begin
                        underrunNext = 1'b1;
                        genModeNext  = MODE_RET;
                        retCntNext   = RET_CNT_LOAD;
                        stateNext    = RET;
                    end
                end
            end

            RET: begin
                genModeNext = MODE_RET;
                if (genDone) begin
                    if (retCntReg == '0) begin
                        frameDoneNext = 1'b1;
                        doGenNext     = 1'b0;
                        stateNext     = IDLE;
                    end else begin
                        retCntNext = retCntReg - 1'b1;
                    end
                end
            end

            default: begin
                genModeNext = MODE_RET;
                doGenNext   = 1'b0;
                stateNext   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg     <= IDLE;
            holdValidReg <= 1'b0;
            holdDataReg  <= '0;
            holdLastReg  <= 1'b0;
            shiftReg     <= '0;
            lastFlagReg  <= 1'b0;
            bitCntReg    <= '0;
            retCntReg    <= '0;
            genModeReg   <= MODE_RET;
            doGenReg     <= 1'b0;
            frameDoneReg <= 1'b0;
            underrunReg  <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            holdValidReg <= holdValidNext;
            holdDataReg  <= holdDataNext;
            holdLastReg  <= holdLastNext;
            shiftReg     <= shiftNext;
            lastFlagReg  <= lastFlagNext;
            bitCntReg    <= bitCntNext;
            retCntReg    <= retCntNext;
            genModeReg   <= genModeNext;
            doGenReg     <= doGenNext;
            frameDoneReg <= frameDoneNext;
            underrunReg  <= underrunNext;
        end
    end

    assign pixelReady = !holdValidReg;
    assign genMode    = genModeReg;
    assign doGen      = doGenReg;
    assign busy       = (stateReg != IDLE);
    assign frameDone  = frameDoneReg;
    assign underrun   = underrunReg;

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Bench for ws2812_pixel_serializer: a cycle stepper drives genDone and pixels, records
// the genMode of every generator slot, and compares against an expected slot list.
module tb_ws2812_pixel_serializer;

    localparam int RET_SLOTS = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] pixelData;
    logic        pixelValid;
    logic        pixelLast;
    logic        pixelReady;
    logic        genDone;
    logic [1:0]  genMode;
    logic        doGen;
    logic        busy;
    logic        frameDone;
    logic        underrun;

    always #5 clk = ~clk;

    ws2812_pixel_serializer #(
        .BITS_PER_PIXEL(24),
        .RET_SLOTS     (RET_SLOTS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pixelData (pixelData),
        .pixelValid(pixelValid),
        .pixelLast (pixelLast),
        .pixelReady(pixelReady),
        .genDone   (genDone),
        .genMode   (genMode),
        .doGen     (doGen),
        .busy      (busy),
        .frameDone (frameDone),
        .underrun  (underrun)
    );

    typedef struct {
        logic [23:0] data;
        logic        last;
        int          atSlot;
    } feedItem;

    int          testsRun    = 0;
    int          testsFailed = 0;
    feedItem     feedQ[$];
    logic [1:0]  obsQ[$];
    logic [1:0]  expQ[$];
    int          gap = 125;
    bit          forceGen = 0;
    int          genCnt = 0;
    bit          presenting = 0;
    int          fdCount, urCount, fdSlot, urSlot;
    logic        fdDoGen;
    int          unstableCnt, badModeCnt;
    logic        prevDoGen = 1'b0;
    logic [1:0]  prevMode = 2'b00;
    bit          prevGenDone = 0;
    int          cycle = 0;
    int          accStep = -1;
    int          riseStep = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, drive genDone and pixel inputs, then
    // let the rising edge happen.
    task automatic step();
        bit acc;
        @(negedge clk);
        if (frameDone === 1'b1) begin fdCount++; fdSlot = obsQ.size(); fdDoGen = doGen; end
        if (underrun === 1'b1) begin urCount++; urSlot = obsQ.size(); end
        if (doGen && prevDoGen && !prevGenDone && genMode !== prevMode) unstableCnt++;
        if (genMode === 2'b01) badModeCnt++;
        if (doGen === 1'b1 && !prevDoGen && riseStep < 0) riseStep = cycle;
        if (doGen === 1'b1 || forceGen) genCnt++;
        else genCnt = 0;
        if (genCnt >= gap) begin genDone = 1'b1; genCnt = 0; end
        else genDone = 1'b0;
        if (genDone && doGen === 1'b1) obsQ.push_back(genMode);
        if (!presenting && feedQ.size() > 0) begin
            if (feedQ[0].atSlot < 0 ||
                (genDone && doGen === 1'b1 && obsQ.size() == feedQ[0].atSlot))
                presenting = 1;
        end
        pixelValid = presenting;
        if (presenting) begin
            pixelData = feedQ[0].data;
            pixelLast = feedQ[0].last;
        end else begin
            pixelData = 24'($urandom);
            pixelLast = 1'($urandom);
        end
        acc = presenting && (pixelReady === 1'b1);
        if (acc && accStep < 0) accStep = cycle;
        prevDoGen = doGen;
        prevMode = genMode;
        prevGenDone = genDone;
        @(posedge clk);
        if (acc) begin
            void'(feedQ.pop_front());
            presenting = 0;
        end
        cycle++;
    endtask

    task automatic clearFrame();
        obsQ.delete();
        expQ.delete();
        fdCount = 0; urCount = 0; fdSlot = -1; urSlot = -1; fdDoGen = 1'b1;
        unstableCnt = 0; badModeCnt = 0; accStep = -1; riseStep = -1;
    endtask

    task automatic feed(input logic [23:0] data, input logic last, input int atSlot);
        feedItem it;
        it.data = data; it.last = last; it.atSlot = atSlot;
        feedQ.push_back(it);
    endtask

    // Reference: each pixel contributes 24 slots {1,bit} MSB first, a frame ends with RET slots.
    task automatic addPixel(input logic [23:0] p);
        for (int b = 23; b >= 0; b--) expQ.push_back({1'b1, p[b]});
    endtask

    task automatic addRet();
        for (int i = 0; i < RET_SLOTS; i++) expQ.push_back(2'b00);
    endtask

    task automatic runFrame(input string name, input int limit);
        int n = 0;
        while (fdCount == 0 && n < limit) begin step(); n++; end
        check({name, "_frame_done_seen"}, 32'(fdCount > 0), 32'd1);
        step();
    endtask

    task automatic checkFrame(input string name, input int expUr, input int urAt);
        int nCmp;
        check({name, "_slot_count"}, obsQ.size(), expQ.size());
        nCmp = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < nCmp; i++)
            check($sformatf("%s_slot%0d", name, i), 32'(obsQ[i]), 32'(expQ[i]));
        check({name, "_frameDone_pulses"}, fdCount, 1);
        check({name, "_frameDone_slot"}, fdSlot, expQ.size());
        check({name, "_doGen_at_frameDone"}, 32'(fdDoGen), 32'd0);
        check({name, "_underrun_pulses"}, urCount, expUr);
        if (expUr > 0) check({name, "_underrun_slot"}, urSlot, urAt);
        check({name, "_genMode_stable"}, unstableCnt, 0);
        check({name, "_genMode_01"}, badModeCnt, 0);
        check({name, "_start_latency"}, riseStep - accStep, 2);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int limit;
        reset = 1'b0;
        genDone = 1'b0;
        pixelValid = 1'b0;
        pixelLast = 1'b0;
        pixelData = '0;
        clearFrame();

        // Reset held low, generator pulsing: outputs stay at their reset values.
        forceGen = 1; gap = 3;
        repeat (6) step();
        check("rst_genMode", 32'(genMode), 32'd0);
        check("rst_doGen", 32'(doGen), 32'd0);
        check("rst_pixelReady", 32'(pixelReady), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        #2 reset = 1'b1;
        repeat (20) step();
        check("idle_genMode", 32'(genMode), 32'd0);
        check("idle_doGen", 32'(doGen), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pixelReady", 32'(pixelReady), 32'd1);
        check("idle_frameDone", fdCount, 0);
        check("idle_no_slots", obsQ.size(), 0);
        forceGen = 0; gap = 125;

        // Single last pixel.
        clearFrame();
        feed(24'hF00F81, 1'b1, -1);
        addPixel(24'hF00F81); addRet();
        runFrame("single", 30 * 130);
        checkFrame("single", 0, 0);

        // Two pixels, second accepted mid-stream into the hold register.
        clearFrame();
        feed(24'hFFFFFF, 1'b0, -1);
        feed(24'h000000, 1'b1, 5);
        addPixel(24'hFFFFFF); addPixel(24'h000000); addRet();
        runFrame("stream", 55 * 130);
        checkFrame("stream", 0, 0);

        // Non-last pixel with nothing after it.
        clearFrame();
        feed(24'h800000, 1'b0, -1);
        addPixel(24'h800000); addRet();
        runFrame("underrun", 30 * 130);
        checkFrame("underrun", 1, 24);

        // Next pixel arrives exactly with the 24th genDone while hold is empty.
        clearFrame();
        feed(24'h5A3C96, 1'b0, -1);
        feed(24'hC3A501, 1'b1, 24);
        addPixel(24'h5A3C96); addPixel(24'hC3A501); addRet();
        runFrame("bypass", 55 * 130);
        checkFrame("bypass", 0, 0);

        // Reset in the middle of a pixel abandons the frame.
        clearFrame();
        feed(24'hAAAAAA, 1'b1, -1);
        limit = 0;
        while (obsQ.size() < 10 && limit < 20 * 130) begin step(); limit++; end
        check("midrst_reached_bit10", obsQ.size(), 10);
        #3 reset = 1'b0;
        #1;
        check("midrst_doGen_async", 32'(doGen), 32'd0);
        check("midrst_genMode_async", 32'(genMode), 32'd0);
        feedQ.delete(); presenting = 0; genCnt = 0;
        repeat (4) step();
        check("midrst_pixelReady", 32'(pixelReady), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_no_frameDone", fdCount, 0);
        check("midrst_no_underrun", urCount, 0);
        #2 reset = 1'b1;
        clearFrame();
        feed(24'h800000, 1'b1, -1);
        addPixel(24'h800000); addRet();
        runFrame("after_rst", 30 * 130);
        checkFrame("after_rst", 0, 0);

        // Randomized frames with shorter generator slots.
        for (int f = 0; f < 8; f++) begin
            int  n;
            bit  endsLast;
            logic [23:0] p;
            string name;
            clearFrame();
            gap = $urandom_range(2, 8);
            n = $urandom_range(1, 3);
            endsLast = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < n; i++) begin
                p = 24'($urandom);
                feed(p, (i == n - 1) && endsLast, -1);
                addPixel(p);
            end
            addRet();
            name = $sformatf("rand%0d", f);
            runFrame(name, (n * 24 + RET_SLOTS + 4) * (gap + 1) + 50);
            checkFrame(name, endsLast ? 0 : 1, n * 24);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
